// File: rtl/riscv_pkg.sv
// riscv_pkg: shared defaults for the RISC-V fetch slice.
// The prefetch buffer keeps its entry type local; only sizing defaults live here.
package riscv_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int PF_DEPTH_DEF = 4;

endpackage

// File: rtl/riscv_if_pf_fifo.sv
// riscv_if_pf_fifo: circular FIFO with synchronous clear.
// Clear wins over pop; a push in the clear cycle lands in slot 0.
module riscv_if_pf_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = PF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= {{(AW-1){1'b0}}, push};
      rp  <= '0;
      cnt <= {{AW{1'b0}}, push};
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[clr ? '0 : wp] <= din;
  end

  assign dout  = mem[rp];
  assign full  = cnt == DEPTH_C;
  assign empty = cnt == '0;

endmodule

// File: rtl/riscv_if_prefetch.sv
// riscv_if_prefetch: pipelined instruction prefetch buffer with flush.
// Define IF_PF_IMEM_ERR_EN to carry imem_err through as if_parcel_page_fault.
module riscv_if_prefetch
  import riscv_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int PARCEL_SIZE = XLEN_DEF,
  parameter int DEPTH       = PF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        if_nxt_pc,
  output logic                   if_stall_nxt_pc,
  input  logic                   if_stall,
  input  logic                   if_flush,
  output logic [PARCEL_SIZE-1:0] if_parcel,
  output logic [XLEN-1:0]        if_parcel_pc,
  output logic                   if_parcel_valid,
  output logic                   if_parcel_misaligned,
  output logic                   if_parcel_page_fault,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_adr,
  input  logic                   imem_stall,
  input  logic                   imem_ack,
`ifdef IF_PF_IMEM_ERR_EN
  input  logic                   imem_err,
`endif
  input  logic [PARCEL_SIZE-1:0] imem_q
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW+1:0] DEPTH_W = DEPTH[CW+1:0];

  typedef struct packed {
    logic [PARCEL_SIZE-1:0] parcel;
    logic [XLEN-1:0]        pc;
    logic                   misaligned;
`ifdef IF_PF_IMEM_ERR_EN
    logic                   fault;
`endif
  } entry_t;

  entry_t          e_in;
  entry_t          e_out;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   live;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   drop_nxt;
  logic [CW-1:0]   drop_fl;
  logic [CW+1:0]   used;
  logic [XLEN-1:0] pc_head;
  logic aligned, credit_ok, issue, mis_push;
  logic stale, ack_push, ack_pop;
  logic p_push, p_pop, p_empty, p_full;
  logic q_empty, q_full;

  assign aligned  = if_nxt_pc[1:0] == 2'b00;
  assign stale    = imem_ack && (drop != '0);
  assign ack_pop  = imem_ack && !stale;
  assign ack_push = ack_pop && !if_flush;

  // After a flush every live request turns stale, including one acked now.
  assign drop_fl = drop + live - {{(CW-1){1'b0}}, imem_ack};

  always_comb begin
    used = {2'b00, occ} + {2'b00, live} + {2'b00, drop};
    if (if_flush) used = {2'b00, drop_fl};
  end

  assign credit_ok = used < DEPTH_W;
  assign issue     = !rst && aligned && credit_ok && !imem_stall;
  assign mis_push  = !rst && !aligned && credit_ok
                   && (if_flush || live == '0);

  assign imem_req        = issue;
  assign imem_adr        = if_nxt_pc;
  assign if_stall_nxt_pc = !(issue || mis_push);

  always_comb begin
    drop_nxt = drop;
    if (if_flush)   drop_nxt = drop_fl;
    else if (stale) drop_nxt = drop - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop <= '0;
    else     drop <= drop_nxt;
  end

  always_comb begin
    e_in            = '0;
    e_in.pc         = if_nxt_pc;
    e_in.misaligned = 1'b1;
    if (ack_push) begin
      e_in.parcel     = imem_q;
      e_in.pc         = pc_head;
      e_in.misaligned = 1'b0;
`ifdef IF_PF_IMEM_ERR_EN
      e_in.fault      = imem_err;
`endif
    end
  end

  assign p_push = ack_push || mis_push;
  assign p_pop  = !p_empty && !if_stall;

  riscv_if_pf_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_parcel_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (p_push),
    .pop   (p_pop),
    .clr   (if_flush),
    .din   (e_in),
    .dout  (e_out),
    .full  (p_full),
    .empty (p_empty),
    .cnt   (occ)
  );

  riscv_if_pf_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (ack_pop),
    .clr   (if_flush),
    .din   (if_nxt_pc),
    .dout  (pc_head),
    .full  (q_full),
    .empty (q_empty),
    .cnt   (live)
  );

  assign if_parcel_valid      = !p_empty;
  assign if_parcel            = p_empty ? '0 : e_out.parcel;
  assign if_parcel_pc         = p_empty ? '0 : e_out.pc;
  assign if_parcel_misaligned = !p_empty && e_out.misaligned;
`ifdef IF_PF_IMEM_ERR_EN
  assign if_parcel_page_fault = !p_empty && e_out.fault;
`else
  assign if_parcel_page_fault = 1'b0;
`endif

  a_ack_orphan: assert property (@(posedge clk) disable iff (rst)
    !(imem_ack && drop == '0 && q_empty));
  a_parcel_ovf: assert property (@(posedge clk) disable iff (rst)
    !(p_push && p_full && !p_pop && !if_flush));
  a_pc_ovf: assert property (@(posedge clk) disable iff (rst)
    !(issue && q_full && !if_flush));

endmodule

// File: tb/tb_riscv_if_prefetch.sv
// tb_riscv_if_prefetch: scoreboard bench for the prefetch buffer.
// Bus model acks in order after a programmable latency.
module tb_riscv_if_prefetch;

`ifdef IF_PF_IMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_nxt_pc;
  logic        if_stall_nxt_pc;
  logic        if_stall;
  logic        if_flush;
  logic [31:0] if_parcel;
  logic [31:0] if_parcel_pc;
  logic        if_parcel_valid;
  logic        if_parcel_misaligned;
  logic        if_parcel_page_fault;
  logic        imem_req;
  logic [31:0] imem_adr;
  logic        imem_stall;
  logic        imem_ack;
  logic [31:0] imem_q;
`ifdef IF_PF_IMEM_ERR_EN
  logic        imem_err;
`endif

  always #5 clk = ~clk;

  riscv_if_prefetch #(
    .XLEN        (32),
    .PARCEL_SIZE (32),
    .DEPTH       (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .if_nxt_pc            (if_nxt_pc),
    .if_stall_nxt_pc      (if_stall_nxt_pc),
    .if_stall             (if_stall),
    .if_flush             (if_flush),
    .if_parcel            (if_parcel),
    .if_parcel_pc         (if_parcel_pc),
    .if_parcel_valid      (if_parcel_valid),
    .if_parcel_misaligned (if_parcel_misaligned),
    .if_parcel_page_fault (if_parcel_page_fault),
    .imem_req             (imem_req),
    .imem_adr             (imem_adr),
    .imem_stall           (imem_stall),
    .imem_ack             (imem_ack),
`ifdef IF_PF_IMEM_ERR_EN
    .imem_err             (imem_err),
`endif
    .imem_q               (imem_q)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] pc;
    logic        mis;
    logic        pf;
  } exp_t;

  typedef struct {
    logic [31:0] adr;
    int          due;
  } bus_t;

  exp_t exp_q[$];
  bus_t bq[$];
  exp_t me;
  bus_t mb;
  bus_t bb;

  int   cyc      = 0;
  int   lat      = 2;
  int   n_req    = 0;
  int   n_pop    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic acc_seen = 1'b0;

  function automatic logic [31:0] dof(input logic [31:0] a);
    return a ^ 32'h0000_0213;
  endfunction

  function automatic logic pf_of(input logic [31:0] a);
    return ERR_EN && (a == 32'h0000_0300);
  endfunction

  // Bus: in-order acks once each request's latency has elapsed.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    imem_ack = 1'b0;
    imem_q   = '0;
`ifdef IF_PF_IMEM_ERR_EN
    imem_err = 1'b0;
`endif
    if (!rst && bq.size() > 0 && bq[0].due <= cyc) begin
      bb       = bq.pop_front();
      imem_ack = 1'b1;
      imem_q   = dof(bb.adr);
`ifdef IF_PF_IMEM_ERR_EN
      imem_err = pf_of(bb.adr);
`endif
    end
  end

  // Scoreboard: record accepted fetches, compare every consumed parcel.
  always @(negedge clk) begin
    if (rst) begin
      acc_seen = 1'b0;
    end else begin
      acc_seen = !if_stall_nxt_pc;
      if (if_flush) begin
        exp_q.delete();
      end else if (if_parcel_valid && !if_stall) begin
        n_pop++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got pc=%h q=%h, required no parcel",
                   if_parcel_pc, if_parcel);
        end else begin
          me = exp_q.pop_front();
          if (if_parcel !== me.q || if_parcel_pc !== me.pc ||
              if_parcel_misaligned !== me.mis ||
              if_parcel_page_fault !== me.pf) begin
            n_fail++;
            $display("FAIL sb_parcel: got q=%h pc=%h mis=%b pf=%b, required q=%h pc=%h mis=%b pf=%b",
                     if_parcel, if_parcel_pc, if_parcel_misaligned,
                     if_parcel_page_fault, me.q, me.pc, me.mis, me.pf);
          end
        end
      end
      if (imem_req && !imem_stall) begin
        mb.adr = imem_adr;
        mb.due = cyc + lat;
        bq.push_back(mb);
        me.q   = dof(if_nxt_pc);
        me.pc  = if_nxt_pc;
        me.mis = 1'b0;
        me.pf  = pf_of(if_nxt_pc);
        exp_q.push_back(me);
        n_req++;
      end else if (!if_stall_nxt_pc) begin
        me.q   = '0;
        me.pc  = if_nxt_pc;
        me.mis = if_nxt_pc[1:0] != 2'b00;
        me.pf  = 1'b0;
        exp_q.push_back(me);
      end
    end
  end

  task automatic step(input bit adv);
    @(posedge clk);
    #1;
    if (adv && acc_seen) if_nxt_pc = if_nxt_pc + 32'd4;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    if_stall   = 1'b0;
    imem_stall = 1'b1;
    if_flush   = 1'b0;
    if_nxt_pc  = 32'h0000_0F00;
    while ((exp_q.size() != 0 || bq.size() != 0) && k < 100) begin
      step(1'b0);
      k++;
    end
    sample();
    n_checks++;
    if (exp_q.size() != 0 || bq.size() != 0 || if_parcel_valid !== 1'b0 ||
        {if_parcel, if_parcel_pc} !== 64'h0) begin
      n_fail++;
      $display("FAIL drain_%s: got pending=%0d bus=%0d valid=%b, required 0 0 0",
               nm, exp_q.size(), bq.size(), if_parcel_valid);
    end
    step(1'b0);
  endtask

  task automatic test_reset();
    sample();
    n_checks++;
    if ({imem_req, if_stall_nxt_pc} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_req: got req=%b stall_nxt=%b, required 0 1",
               imem_req, if_stall_nxt_pc);
    end
    n_checks++;
    if ({if_parcel_valid, if_parcel_misaligned, if_parcel_page_fault} !== 3'b000 ||
        {if_parcel, if_parcel_pc} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%b q=%h pc=%h, required all 0",
               if_parcel_valid, if_parcel, if_parcel_pc);
    end
    step(1'b0);
  endtask

  task automatic test_single();
    rst        = 1'b0;
    lat        = 2;
    if_nxt_pc  = 32'h0000_0200;
    if_stall   = 1'b1;
    imem_stall = 1'b0;
    sample();
    n_checks++;
    if ({imem_req, if_stall_nxt_pc} !== 2'b10 || imem_adr !== 32'h200) begin
      n_fail++;
      $display("FAIL single_issue: got req=%b stall_nxt=%b adr=%h, required 1 0 200",
               imem_req, if_stall_nxt_pc, imem_adr);
    end
    step(1'b0);
    imem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      n_checks++;
      if (if_parcel_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early: got valid=%b at +%0d, required 0",
                 if_parcel_valid, i + 1);
      end
      step(1'b0);
    end
    sample();
    n_checks++;
    if (if_parcel_valid !== 1'b1 || if_parcel !== 32'h13 ||
        if_parcel_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL single_data: got valid=%b q=%h pc=%h, required 1 00000013 00000200",
               if_parcel_valid, if_parcel, if_parcel_pc);
    end
    step(1'b0);
    drain("single");
  endtask

  task automatic test_credit();
    int br;
    int bp;
    lat        = 2;
    if_stall   = 1'b1;
    imem_stall = 1'b0;
    if_nxt_pc  = 32'h0000_0200;
    br         = n_req;
    for (int i = 0; i < 8; i++) begin
      sample();
      step(1'b1);
    end
    sample();
    n_checks++;
    if (n_req - br != 4 || if_nxt_pc !== 32'h210 || imem_req !== 1'b0 ||
        if_stall_nxt_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_full: got issued=%0d pc=%h req=%b stall_nxt=%b, required 4 210 0 1",
               n_req - br, if_nxt_pc, imem_req, if_stall_nxt_pc);
    end
    n_checks++;
    if (if_parcel_valid !== 1'b1 || if_parcel_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL credit_head: got valid=%b pc=%h, required 1 200",
               if_parcel_valid, if_parcel_pc);
    end
    step(1'b1);
    if_stall = 1'b0;
    br       = n_req;
    bp       = n_pop;
    for (int i = 0; i < 12; i++) begin
      sample();
      n_checks++;
      if (n_req - br > n_pop - bp) begin
        n_fail++;
        $display("FAIL credit_pop: got issued=%0d pops=%0d, required issued<=pops",
                 n_req - br, n_pop - bp);
      end
      step(1'b1);
    end
    n_checks++;
    if (n_req - br < 6) begin
      n_fail++;
      $display("FAIL credit_rate: got %0d issues in 12 cycles, required >=6",
               n_req - br);
    end
    drain("credit");
  endtask

  task automatic test_flush();
    int k;
    lat        = 6;
    if_stall   = 1'b0;
    imem_stall = 1'b0;
    if_nxt_pc  = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      sample();
      step(1'b1);
    end
    if_nxt_pc = 32'h0000_0400;
    if_flush  = 1'b1;
    sample();
    n_checks++;
    if (imem_req !== 1'b1 || imem_adr !== 32'h400) begin
      n_fail++;
      $display("FAIL flush_issue: got req=%b adr=%h, required 1 400",
               imem_req, imem_adr);
    end
    step(1'b0);
    if_flush   = 1'b0;
    imem_stall = 1'b1;
    k = 0;
    while (k < 30) begin
      sample();
      if (if_parcel_valid === 1'b1) break;
      step(1'b0);
      k++;
    end
    n_checks++;
    if (k != 6 || if_parcel_pc !== 32'h400 || if_parcel !== dof(32'h400)) begin
      n_fail++;
      $display("FAIL flush_first: got wait=%0d pc=%h q=%h, required 6 400 %h",
               k, if_parcel_pc, if_parcel, dof(32'h400));
    end
    step(1'b0);
    drain("flush");
  endtask

  task automatic test_flush_ack();
    lat        = 2;
    if_stall   = 1'b1;
    imem_stall = 1'b0;
    if_nxt_pc  = 32'h0000_0500;
    sample();
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fack_issue: got req=%b, required 1", imem_req);
    end
    step(1'b1);
    sample();
    step(1'b1);
    imem_stall = 1'b1;
    sample();
    step(1'b0);
    if_stall = 1'b0;
    if_flush = 1'b1;
    sample();
    n_checks++;
    if (if_parcel_valid !== 1'b1 || if_parcel_pc !== 32'h500) begin
      n_fail++;
      $display("FAIL fack_head: got valid=%b pc=%h, required 1 500",
               if_parcel_valid, if_parcel_pc);
    end
    step(1'b0);
    if_flush = 1'b0;
    if_stall = 1'b1;
    sample();
    n_checks++;
    if (if_parcel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fack_valid: got valid=%b, required 0", if_parcel_valid);
    end
    step(1'b0);
    imem_stall = 1'b0;
    if_nxt_pc  = 32'h0000_0604;
    sample();
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fack_reissue: got req=%b, required 1", imem_req);
    end
    step(1'b0);
    drain("flush_ack");
  endtask

  task automatic test_misaligned();
    int w;
    lat        = 3;
    if_stall   = 1'b1;
    imem_stall = 1'b0;
    if_nxt_pc  = 32'h0000_0202;
    sample();
    n_checks++;
    if ({imem_req, if_stall_nxt_pc} !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_accept: got req=%b stall_nxt=%b, required 0 0",
               imem_req, if_stall_nxt_pc);
    end
    step(1'b0);
    if_nxt_pc  = 32'h0000_0210;
    imem_stall = 1'b1;
    sample();
    n_checks++;
    if ({if_parcel_valid, if_parcel_misaligned} !== 2'b11 ||
        if_parcel_pc !== 32'h202 || if_parcel !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_entry: got valid=%b mis=%b pc=%h q=%h, required 1 1 202 0",
               if_parcel_valid, if_parcel_misaligned, if_parcel_pc, if_parcel);
    end
    step(1'b0);
    drain("mis0");
    imem_stall = 1'b0;
    if_stall   = 1'b1;
    if_nxt_pc  = 32'h0000_0700;
    sample();
    step(1'b0);
    if_nxt_pc  = 32'h0000_0702;
    imem_stall = 1'b1;
    w = 0;
    while (w < 20) begin
      sample();
      if (if_stall_nxt_pc === 1'b0) break;
      step(1'b0);
      w++;
    end
    n_checks++;
    if (w != 3 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_wait: got stalls=%0d req=%b, required 3 0", w, imem_req);
    end
    step(1'b0);
    drain("mis1");
  endtask

  task automatic test_fault();
    logic [31:0] epc;
    lat        = 1;
    if_stall   = 1'b1;
    imem_stall = 1'b0;
    if_nxt_pc  = 32'h0000_02F8;
    for (int i = 0; i < 4; i++) begin
      sample();
      step(1'b1);
    end
    imem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      step(1'b0);
    end
    if_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      epc = 32'h0000_02F8 + 32'(4 * i);
      sample();
      n_checks++;
      if (if_parcel_pc !== epc || if_parcel_page_fault !== (ERR_EN && i == 2)) begin
        n_fail++;
        $display("FAIL fault_%0d: got pc=%h pf=%b, required %h %b",
                 i, if_parcel_pc, if_parcel_page_fault, epc, ERR_EN && i == 2);
      end
      step(1'b0);
    end
    drain("fault");
  endtask

  initial begin
    rst        = 1'b1;
    if_nxt_pc  = 32'h0000_0200;
    if_stall   = 1'b1;
    if_flush   = 1'b0;
    imem_stall = 1'b0;
    imem_ack   = 1'b0;
    imem_q     = '0;
`ifdef IF_PF_IMEM_ERR_EN
    imem_err   = 1'b0;
`endif
    test_reset();
    test_single();
    test_credit();
    test_flush();
    test_flush_ack();
    test_misaligned();
    test_fault();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
